rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (rd_wb / result / register_write) among NUM_REQ writeback sources: ALU, load/store unit, multiply/divide unit.
- Round-robin arbitration with valid/ready handshakes and a registered output stage.
- Saturating per-requester grant counters for performance debug.
- Runs on posedge clk. The register file samples the output on the following negedge.

Parameters:
- NUM_REQ, 3, number of writeback requesters; legal range 2..8; index 0 = ALU, 1 = LSU, 2 = MDU.
- DATA_W, 32, writeback data width.
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk  in  1  clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester writeback pending.
- req_rd  in  5*NUM_REQ  destination register; slice i = [5i+4:5i].
- req_data  in  DATA_W*NUM_REQ  writeback value; slice i = [DATA_W*i+DATA_W-1:DATA_W*i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- stall  in  1  pipeline stall; freezes the arbiter.
- wb_en  out  1  register_write strobe to the RF.
- wb_rd  out  5  rd_wb to the RF.
- wb_data  out  DATA_W  result to the RF.
- wb_src  out  3  index of the requester that produced the current output.
- cnt_sel  in  3  grant-counter select.
- cnt_val  out  CNT_W  grant count of requester cnt_sel.
- cnt_clr  in  1  synchronous clear of all grant counters.

Behaviour:
- Reset (async on rst_n low): wb_en=0, wb_rd=0, wb_data=0, wb_src=0, RR pointer=0, all counters=0, req_ready=0.
- req_ready is combinational from req_valid, the pointer and stall.
  - If stall=1: req_ready=0.
  - Otherwise grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - At most one bit of req_ready is set. req_ready[i]=1 only if req_valid[i]=1.
- On a posedge with stall=0 and a grant to requester g:
  - wb_en <= (req_rd[g] != 0).
  - wb_rd <= req_rd[g]; wb_data <= req_data[g]; wb_src <= g.
  - ptr <= (g+1) mod NUM_REQ.
  - counter[g] <= counter[g]+1, saturating at all-ones.
- On a posedge with stall=0 and no valid request: wb_en <= 0; wb_rd, wb_data, wb_src and ptr hold.
- On a posedge with stall=1: all registers hold, including wb_en. The RF ignores the port while stalled.
- Latency: grant cycle N; output valid from the edge ending cycle N until the next edge.
- Throughput: one writeback per non-stalled cycle.
- rd=0 requests are granted and consumed (pointer advances, counter increments) but drive wb_en=0. This releases the source without writing $zero.
- Fairness: a continuously valid requester is granted within NUM_REQ non-stalled cycles.
- Same rd from two requesters in one cycle: the RR winner writes first; the other writes in a later cycle. Ordering between sources is the scheduler's responsibility, not this block's.
- Requester contract: once req_valid is high it stays high with stable rd/data until accepted. The arbiter does not check this.
- Counters:
  - cnt_clr has priority over an increment in the same cycle; cleared counters read 0 next cycle.
  - cnt_val is combinational from cnt_sel; cnt_sel >= NUM_REQ reads 0.
- Reset asserted mid-transfer: output and pointer clear immediately. Pending requests are re-arbitrated from ptr=0 after rst_n rises.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, wb_en=0, wb_rd=0, cnt_val=0. Release -> first grant goes to requester 0.
- Single request: ALU valid, rd=5, data=0x1234 -> req_ready=001 that cycle; next cycle wb_en=1, wb_rd=5, wb_data=0x1234, wb_src=0.
- All three valid continuously for 6 cycles -> grants 0,1,2,0,1,2; cnt_val reads 2 for each requester.
- Stall: LSU valid with stall=1 for 3 cycles -> req_ready=0 and outputs frozen. Stall drops -> LSU is granted the next cycle.
- rd=0: MDU valid, rd=0, data=0xFFFF -> granted; wb_en=0 next cycle; MDU counter increments; ptr advances to 0.
- Saturation and clear (CNT_W=4): 20 ALU grants -> cnt_val=15. cnt_clr together with a grant -> counter reads 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the single register-file write port among NUM_REQ writeback sources
// (index 0 = ALU, 1 = LSU, 2 = MDU). A round-robin pointer selects which
// valid requester is granted. The grant is returned combinationally on
// req_ready. The granted writeback is captured into a registered output stage
// on the same clock edge, and the RF samples it on the following negedge.
// Each requester also has a saturating grant counter for performance debug.
//
// Ports
//   clk        in   clock, posedge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]         per-requester writeback pending
//   req_rd     in   [5*NUM_REQ]       destination register, slice i = [5i+4:5i]
//   req_data   in   [DATA_W*NUM_REQ]  writeback value, slice i = [DATA_W*i +: DATA_W]
//   req_ready  out  [NUM_REQ]         one-hot grant (combinational)
//   stall      in   pipeline stall, freezes the arbiter
//   wb_en      out  register_write strobe to the RF
//   wb_rd      out  [5]      rd_wb to the RF
//   wb_data    out  [DATA_W] result to the RF
//   wb_src     out  [3]      index of the requester behind the current output
//   cnt_sel    in   [3]      grant-counter select
//   cnt_val    out  [CNT_W]  grant count of requester cnt_sel (0 if out of range)
//   cnt_clr    in   synchronous clear of all grant counters
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [5*NUM_REQ-1:0]      req_rd,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      stall,
   output logic                      wb_en,
   output logic [4:0]                wb_rd,
   output logic [DATA_W-1:0]         wb_data,
   output logic [2:0]                wb_src,
   input  logic [2:0]                cnt_sel,
   output logic [CNT_W-1:0]          cnt_val,
   input  logic                      cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Registered state
   logic [2:0]        ptr_q;
   logic [2:0]        ptr_d;
   logic              wb_en_q;
   logic [4:0]        wb_rd_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [2:0]        wb_src_q;
   logic [CNT_W-1:0]  cnt_q [NUM_REQ];

   // Arbitration results
   logic              grant_s;
   logic [2:0]        gidx_s;
   logic [3:0]        idx_s;
   logic [4:0]        sel_rd_s;
   logic [DATA_W-1:0] sel_data_s;

   // Round-robin search: scan ptr, ptr+1, ... (mod NUM_REQ) and take the first
   // valid requester. Reset and stall both suppress any grant, so req_ready is
   // zero while rst_n is low even if requesters are pending.
   always_comb begin
      grant_s = 1'b0;
      gidx_s  = 3'd0;
      idx_s   = 4'd0;
      if (rst_n && !stall) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, ptr_q} + 4'(k);
            if (idx_s >= 4'(NUM_REQ)) begin
               idx_s = idx_s - 4'(NUM_REQ);
            end else begin
               idx_s = idx_s;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
               if (!grant_s && (idx_s == 4'(j)) && req_valid[j]) begin
                  grant_s = 1'b1;
                  gidx_s  = 3'(j);
               end else begin
                  grant_s = grant_s;
               end
            end
         end
      end else begin
         grant_s = 1'b0;
      end
   end

   // One-hot grant vector back to the requesters.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = grant_s && (gidx_s == 3'(i));
      end
   end

   // Mux the winner's rd/data and compute the pointer that follows it.
   always_comb begin
      sel_rd_s   = 5'd0;
      sel_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx_s == 3'(i)) begin
            sel_rd_s   = req_rd[5*i +: 5];
            sel_data_s = req_data[DATA_W*i +: DATA_W];
         end else begin
            sel_rd_s   = sel_rd_s;
            sel_data_s = sel_data_s;
         end
      end
      if (gidx_s == 3'(NUM_REQ-1)) begin
         ptr_d = 3'd0;
      end else begin
         ptr_d = gidx_s + 3'd1;
      end
   end

   // Writeback output stage and round-robin pointer. A stall freezes every
   // register, wb_en included. An idle cycle only drops the strobe. An rd=0
   // grant still consumes the request but never writes $zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en_q   <= 1'b0;
         wb_rd_q   <= 5'd0;
         wb_data_q <= '0;
         wb_src_q  <= 3'd0;
         ptr_q     <= 3'd0;
      end else if (!stall) begin
         if (grant_s) begin
            wb_en_q   <= (sel_rd_s != 5'd0);
            wb_rd_q   <= sel_rd_s;
            wb_data_q <= sel_data_s;
            wb_src_q  <= gidx_s;
            ptr_q     <= ptr_d;
         end else begin
            wb_en_q   <= 1'b0;
         end
      end else begin
         wb_en_q <= wb_en_q;
      end
   end

   // Saturating per-requester grant counters. A clear wins over a same-cycle
   // increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (cnt_clr) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (grant_s) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((gidx_s == 3'(i)) && (cnt_q[i] != CNT_MAX)) begin
               cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end else begin
               cnt_q[i] <= cnt_q[i];
            end
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= cnt_q[i];
         end
      end
   end

   // Debug read mux. Selects beyond NUM_REQ read as zero.
   always_comb begin
      cnt_val = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cnt_sel == 3'(i)) begin
            cnt_val = cnt_q[i];
         end else begin
            cnt_val = cnt_val;
         end
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_rd   = wb_rd_q;
   assign wb_data = wb_data_q;
   assign wb_src  = wb_src_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Self-checking bench for rf_wb_arbiter (NUM_REQ=3, DATA_W=32, CNT_W=4).
// A behavioural model (pointer, output copy, counter array) is advanced once
// per clock from the arbitration rules. Each cycle, all DUT outputs are
// compared against the model at the negedge. Directed scenarios run first,
// followed by a randomized phase that obeys the requester contract.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

   localparam int N    = 3;
   localparam int DW   = 32;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [5*N-1:0]    req_rd;
   logic [DW*N-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              stall;
   logic              wb_en;
   logic [4:0]        wb_rd;
   logic [DW-1:0]     wb_data;
   logic [2:0]        wb_src;
   logic [2:0]        cnt_sel;
   logic [CW-1:0]     cnt_val;
   logic              cnt_clr;

   int n_cmp = 0;
   int n_bad = 0;

   // Requester-side state
   bit          v   [N];
   int          rdv [N];
   logic [31:0] dv  [N];

   // Reference model state
   int          m_ptr;
   bit          m_en;
   int          m_rd;
   logic [31:0] m_data;
   int          m_src;
   int          m_cnt [N];

   logic [N-1:0] seen_ready;
   int           last_g;

   rf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .req_ready (req_ready),
      .stall     (stall),
      .wb_en     (wb_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_src    (wb_src),
      .cnt_sel   (cnt_sel),
      .cnt_val   (cnt_val),
      .cnt_clr   (cnt_clr)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_en   = 1'b0;
      m_rd   = 0;
      m_data = 32'd0;
      m_src  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   // Expected winner: first pending requester at or after the pointer, wrapping.
   function automatic int arb();
      if (!rst_n || stall) return -1;
      for (int k = 0; k < N; k++) begin
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input int rd, input logic [31:0] d);
      v[i]   = 1'b1;
      rdv[i] = rd;
      dv[i]  = d;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = v[i];
         req_rd[5*i +: 5]     = 5'(rdv[i]);
         req_data[DW*i +: DW] = dv[i];
      end
   endtask

   // One clock: drive, check everything at negedge, advance model at posedge.
   task automatic cycle();
      int g;
      logic [N-1:0] er;
      drive();
      @(negedge clk);
      if (!rst_n) model_reset();
      g  = arb();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      seen_ready = req_ready;
      chk("req_ready", req_ready, er);
      chk("wb_en",     wb_en,     m_en);
      chk("wb_rd",     wb_rd,     m_rd);
      chk("wb_data",   wb_data,   m_data);
      chk("wb_src",    wb_src,    m_src);
      chk("cnt_val",   cnt_val,   (cnt_sel < N) ? m_cnt[cnt_sel] : 0);
      @(posedge clk);
      if (rst_n) begin
         if (cnt_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
         if (!stall) begin
            if (g >= 0) begin
               m_en   = (rdv[g] != 0);
               m_rd   = rdv[g];
               m_data = dv[g];
               m_src  = g;
               m_ptr  = (g + 1) % N;
               if (!cnt_clr && m_cnt[g] < CMAX) m_cnt[g]++;
               v[g] = 1'b0;
            end else begin
               m_en = 1'b0;
            end
         end
      end
      last_g = g;
      #1;
   endtask

   initial begin
      stall   = 1'b0;
      cnt_clr = 1'b0;
      cnt_sel = 3'd0;
      for (int i = 0; i < N; i++) begin v[i] = 1'b0; rdv[i] = 0; dv[i] = 32'd0; end
      model_reset();

      // Reset with everyone pending
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, i + 1, 32'hA0 + 32'(i));
      repeat (2) cycle();
      chk("rst_ready", seen_ready, 3'b000);
      chk("rst_wb_en", wb_en, 1'b0);
      chk("rst_wb_rd", wb_rd, 5'd0);
      chk("rst_cnt",   cnt_val, 4'd0);

      // Release: round robin over three continuously valid sources
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) if (!v[i]) set_req(i, i + 1, 32'(c * 16 + i));
         cycle();
         chk("rr_order", last_g, c % N);
      end
      for (int i = 0; i < N; i++) begin
         cnt_sel = 3'(i);
         #1;
         chk("rr_cnt", cnt_val, 4'd2);
      end
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      cnt_sel = 3'd0;

      // Single ALU request
      set_req(0, 5, 32'h1234);
      cycle();
      chk("single_ready", seen_ready, 3'b001);
      chk("single_en",    wb_en,   1'b1);
      chk("single_rd",    wb_rd,   5'd5);
      chk("single_data",  wb_data, 32'h1234);
      chk("single_src",   wb_src,  3'd0);

      // LSU held off by stall, then granted
      set_req(1, 9, 32'h5555);
      stall = 1'b1;
      repeat (3) begin
         cycle();
         chk("stall_ready", seen_ready, 3'b000);
         chk("stall_hold",  wb_rd, 5'd5);
      end
      stall = 1'b0;
      cycle();
      chk("unstall_ready", seen_ready, 3'b010);
      chk("unstall_rd",    wb_rd, 5'd9);

      // MDU with rd=0: consumed, no write strobe, counter still moves
      set_req(2, 0, 32'hFFFF);
      cycle();
      chk("rd0_ready", seen_ready, 3'b100);
      chk("rd0_en",    wb_en, 1'b0);
      cnt_sel = 3'd2;
      #1;
      chk("rd0_cnt", cnt_val, 4'd3);
      set_req(0, 7, 32'd1);
      set_req(2, 8, 32'd2);
      cycle();
      chk("ptr_wrap", seen_ready, 3'b001);
      v[2] = 1'b0;

      // Saturation and clear-over-increment
      cnt_sel = 3'd0;
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      for (int c = 0; c < 20; c++) begin
         set_req(0, 3, 32'(c));
         cycle();
      end
      #1;
      chk("sat_cnt", cnt_val, 4'd15);
      set_req(0, 4, 32'd99);
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      #1;
      chk("clr_cnt", cnt_val, 4'd0);
      cycle();

      // Randomized traffic
      for (int r = 0; r < 400; r++) begin
         stall   = ($urandom_range(0, 4) == 0);
         cnt_clr = ($urandom_range(0, 39) == 0);
         cnt_sel = 3'($urandom_range(0, 7));
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 1) == 1)
               set_req(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31), $urandom());
         end
         cycle();
      end
      stall   = 1'b0;
      cnt_clr = 1'b0;

      // Reset mid-transfer: outputs clear at once, re-arbitration from 0
      for (int i = 0; i < N; i++) if (!v[i]) set_req(i, 10 + i, 32'hBEEF0000 + 32'(i));
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_en",  wb_en,  1'b0);
      chk("midrst_rd",  wb_rd,  5'd0);
      chk("midrst_src", wb_src, 3'd0);
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) if (!v[i]) set_req(i, 10 + i, 32'hBEEF0000 + 32'(i));
      cycle();
      chk("midrst_first", seen_ready, 3'b001);
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
